// File: rtl/sum_display_scan.sv
// Converts a 5-bit adder result to two BCD digits and scans them
// onto a two-digit multiplexed 7-segment display.
module sum_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       cout4,
  input  logic [3:0] s,
  output logic [3:0] bcd,
  output logic [1:0] an,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [4:0]    bin;
  logic [7:0]    scr;
  logic [3:0]    tens;
  logic [3:0]    units;
  logic [CW-1:0] rcnt;
  logic          sel;
  logic          armed;
  logic [7:0]    adj;
  logic [12:0]   shifted;

  // one double-dabble step over {tens, units, remaining binary}
  always_comb begin
    adj = scr;
    if (scr[3:0] >= 4'd5) adj[3:0] = scr[3:0] + 4'd3;
    if (scr[7:4] >= 4'd5) adj[7:4] = scr[7:4] + 4'd3;
    shifted = {adj, bin} << 1;
  end

  // armed stays low on the release edge so no load is taken there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
      bin   <= 5'd0;
      scr   <= 8'd0;
      tens  <= 4'd0;
      units <= 4'd0;
      done  <= 1'b0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (load && armed) begin
            bin   <= {cout4, s};
            scr   <= 8'd0;
            cnt   <= 3'd0;
            state <= CONV;
          end
        end
        CONV: begin
          scr <= shifted[12:5];
          bin <= shifted[4:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd4) state <= COMMIT;
        end
        COMMIT: begin
          tens  <= scr[7:4];
          units <= scr[3:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      sel  <= 1'b0;
    end else if (rcnt == LAST) begin
      rcnt <= '0;
      sel  <= ~sel;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd = units;
    an  = 2'b10;
    if (sel) begin
      bcd = tens;
      an  = (BLANK_LZ && tens == 4'd0) ? 2'b11 : 2'b01;
    end
  end

endmodule

// File: tb/tb_sum_display_scan.sv
// Self-checking bench for sum_display_scan: conversion latency,
// digit values, display scanning, load-while-busy and reset abort.
module tb_sum_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic       cout4;
  logic [3:0] s;
  logic [3:0] bcd;
  logic [1:0] an;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int n_edges;
  int exp_t = 0;
  int exp_u = 0;

  sum_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .cout4(cout4), .s(s),
    .bcd(bcd), .an(an), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // edges seen since reset release; the slot shown is (n/4) mod 2
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else n_edges <= n_edges + 1;
  end

  function automatic logic [5:0] scan_exp(int n, int t, int u);
    if (((n / 4) % 2) == 0) return {2'b10, 4'(u)};
    if (t == 0) return {2'b11, 4'(t)};
    return {2'b01, 4'(t)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; cout4 = 1'b0; s = 4'd0;
    #2;
    checks++;
    if ({busy, done, an, bcd} !== {1'b0, 1'b0, 2'b10, 4'd0}) begin
      errors++;
      $display("FAIL reset_state got %b want 0010_0000",
               {busy, done, an, bcd});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [5:0] e;
    repeat (20) begin
      @(posedge clk); #1;
      e = scan_exp(n_edges, exp_t, exp_u);
      checks++;
      if ({busy, done} !== 2'b00 || {an, bcd} !== e) begin
        errors++;
        $display("FAIL idle_scan n=%0d got bd=%b an/bcd=%b want 00 %b",
                 n_edges, {busy, done}, {an, bcd}, e);
      end
    end
  endtask

  task automatic test_convert(input int v, input string tag);
    int lat;
    logic [5:0] e;
    @(posedge clk); #1;
    load = 1'b1; {cout4, s} = 5'(v);
    @(posedge clk); #1;
    load = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      e = scan_exp(n_edges, exp_t, exp_u);
      checks++;
      if (busy !== 1'b1 || {an, bcd} !== e) begin
        errors++;
        $display("FAIL %s busy/scan lat=%0d got %b %b want 1 %b",
                 tag, lat, busy, {an, bcd}, e);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s latency got %0d busy=%b want 6 busy=0",
               tag, lat, busy);
    end
    exp_t = v / 10;
    exp_u = v % 10;
    repeat (8) begin
      e = scan_exp(n_edges, exp_t, exp_u);
      checks++;
      if ({an, bcd} !== e) begin
        errors++;
        $display("FAIL %s digits v=%0d got %b want %b",
                 tag, v, {an, bcd}, e);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s done_width got %b want 0", tag, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [5:0] e;
    @(posedge clk); #1;
    load = 1'b1; {cout4, s} = 5'd16;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    load = 1'b1; {cout4, s} = 5'd5;
    @(posedge clk); #1;
    load = 1'b0;
    pulses = 0;
    repeat (15) begin
      if (done === 1'b1) begin
        pulses++;
        exp_t = 1;
        exp_u = 6;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses got %0d want 1", pulses);
    end
    repeat (8) begin
      e = scan_exp(n_edges, exp_t, exp_u);
      checks++;
      if ({an, bcd} !== e || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_digits got %b busy=%b want %b busy=0",
                 {an, bcd}, busy, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    load = 1'b1; {cout4, s} = 5'd31;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_t = 0;
    exp_u = 0;
    #1;
    checks++;
    if ({busy, done, an, bcd} !== {1'b0, 1'b0, 2'b10, 4'd0}) begin
      errors++;
      $display("FAIL abort_state got %b want 0010_0000",
               {busy, done, an, bcd});
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_hold got done=%b busy=%b want 0 0",
                 done, busy);
      end
    end
    rst_n = 1'b1;
    test_convert(15, "after_abort");
  endtask

  task automatic test_boundaries();
    int vals[4] = '{0, 31, 9, 10};
    foreach (vals[i]) test_convert(vals[i], "boundary");
  endtask

  task automatic test_random();
    repeat (10) test_convert(int'($urandom_range(0, 31)), "random");
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_convert(5, "value5");
    test_convert(30, "value30");
    test_back_to_back();
    test_reset_abort();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
